lod_pipe: RTL and testbench

Parametrised, pipelined leading-one detector with valid/ready flow control, the next generation of the fixed 8-bit nibble-merge LOD. It finds the leading-one position of a WIDTH-bit operand with a registered binary merge tree, then left-aligns the bits below the leading one to form the Mitchell fraction. It feeds the log-domain conversion stage of the log multiplier datapath and carries a sideband tag so results can be matched to operands.

---
 rtl/lod_pkg.sv | 26 ++
 rtl/lod_pipe_if.sv | 31 +++
 rtl/lod_merge.sv | 25 ++
 rtl/lod_pipe.sv | 152 +++++++++++++++
 tb/tb_lod_pipe.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/lod_pkg.sv
// Shared constants and sizing helpers for the pipelined leading-one detector
// and the log-domain stages that need to line up with its latency.
package lod_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // A node at tree level L encodes positions 0 .. 2^(L+1)-1.
  function automatic int pos_width(input int level);
    return level + 1;
  endfunction

  function automatic int lod_lat(input int width);
    return clog2(width) + 1;
  endfunction

  localparam int LOD_WIDTH_DEFAULT = 16;
  localparam int LOD_LAT = lod_lat(LOD_WIDTH_DEFAULT);

endpackage

// File: rtl/lod_pipe_if.sv
// Operand and result channels of the leading-one detector, both valid/ready.
interface lod_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  import lod_pkg::*;

  localparam int LOG2W = clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [LOG2W-1:0] out_pos;
  logic             out_zero;
  logic [WIDTH-2:0] out_frac;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_pos, out_zero, out_frac, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_pos, out_zero, out_frac, out_tag
  );

endinterface

// File: rtl/lod_merge.sv
// Combinational 2:1 merge of two (valid, pos) leading-one results; the upper
// half wins whenever it holds a one.
module lod_merge #(
  parameter int PW = 1
) (
  input  logic          v_hi,
  input  logic          v_lo,
  input  logic [PW-1:0] pos_hi,
  input  logic [PW-1:0] pos_lo,
  output logic          v,
  output logic [PW:0]   pos
);

  always_comb begin
    v = v_hi | v_lo;
    if (v_hi) begin
      pos = {1'b1, pos_hi};
    end else if (v_lo) begin
      pos = {1'b0, pos_lo};
    end else begin
      pos = {(PW + 1){1'b0}};
    end
  end

endmodule

// File: rtl/lod_pipe.sv
// Pipelined leading-one detector: a registered binary merge tree finds the
// leading one, then a final shifter left-aligns the bits below it.
module lod_pipe
  import lod_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input logic       clk,
  input logic       rst,
  lod_pipe_if.slave bus
);

  localparam int LOG2W = clog2(WIDTH);
  localparam int LAST  = LOG2W - 1;

  logic                 en;
  logic [LOG2W-1:0]     stg_valid_d, stg_valid_q;
  logic [WIDTH-1:0]     stg_data_d [LOG2W];
  logic [WIDTH-1:0]     stg_data_q [LOG2W];
  logic [TAG_W-1:0]     stg_tag_d  [LOG2W];
  logic [TAG_W-1:0]     stg_tag_q  [LOG2W];

  logic                 final_v;
  logic [LOG2W-1:0]     final_pos;

  logic                 out_valid_d, out_valid_q;
  logic [LOG2W-1:0]     out_pos_d, out_pos_q;
  logic                 out_zero_d, out_zero_q;
  logic [WIDTH-2:0]     out_frac_d, out_frac_q;
  logic [TAG_W-1:0]     out_tag_d, out_tag_q;

  // One global enable: the whole pipe advances unless a result is stuck at the output.
  assign en           = !out_valid_q | bus.out_ready;
  assign bus.in_ready = en;

  always_comb begin
    stg_valid_d[0] = bus.in_valid;
    stg_data_d[0]  = bus.in_data;
    stg_tag_d[0]   = bus.in_tag;
    for (int s = 1; s < LOG2W; s++) begin
      stg_valid_d[s] = stg_valid_q[s-1];
      stg_data_d[s]  = stg_data_q[s-1];
      stg_tag_d[s]   = stg_tag_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid_q <= {LOG2W{1'b0}};
      for (int s = 0; s < LOG2W; s++) begin
        stg_data_q[s] <= {WIDTH{1'b0}};
        stg_tag_q[s]  <= {TAG_W{1'b0}};
      end
    end else if (en) begin
      stg_valid_q <= stg_valid_d;
      for (int s = 0; s < LOG2W; s++) begin
        stg_data_q[s] <= stg_data_d[s];
        stg_tag_q[s]  <= stg_tag_d[s];
      end
    end
  end

  for (genvar l = 0; l < LOG2W; l++) begin : g_lvl
    localparam int N  = WIDTH >> (l + 1);
    localparam int PW = pos_width(l);

    logic [N-1:0]  v_d, v_q;
    logic [PW-1:0] pos_d [N];
    logic [PW-1:0] pos_q [N];

    if (l == 0) begin : g_leaf
      always_comb begin
        for (int i = 0; i < N; i++) begin
          v_d[i]   = bus.in_data[2*i+1] | bus.in_data[2*i];
          pos_d[i] = bus.in_data[2*i+1];
        end
      end
    end else begin : g_merge
      for (genvar i = 0; i < N; i++) begin : g_node
        lod_merge #(.PW(PW - 1)) u_merge (
          .v_hi   (g_lvl[l-1].v_q[2*i+1]),
          .v_lo   (g_lvl[l-1].v_q[2*i]),
          .pos_hi (g_lvl[l-1].pos_q[2*i+1]),
          .pos_lo (g_lvl[l-1].pos_q[2*i]),
          .v      (v_d[i]),
          .pos    (pos_d[i])
        );
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= {N{1'b0}};
        for (int i = 0; i < N; i++) begin
          pos_q[i] <= {PW{1'b0}};
        end
      end else if (en) begin
        v_q <= v_d;
        for (int i = 0; i < N; i++) begin
          pos_q[i] <= pos_d[i];
        end
      end
    end
  end

  assign final_v   = g_lvl[LAST].v_q[0];
  assign final_pos = g_lvl[LAST].pos_q[0];

  // Bubbles leave the output fields at zero; ~pos equals WIDTH-1-pos since WIDTH is 2^LOG2W.
  always_comb begin
    out_valid_d = stg_valid_q[LAST];
    out_pos_d   = {LOG2W{1'b0}};
    out_zero_d  = 1'b0;
    out_frac_d  = {(WIDTH - 1){1'b0}};
    out_tag_d   = {TAG_W{1'b0}};
    if (stg_valid_q[LAST]) begin
      out_tag_d = stg_tag_q[LAST];
      if (final_v) begin
        out_pos_d  = final_pos;
        out_frac_d = (WIDTH - 1)'(stg_data_q[LAST] << (~final_pos));
      end else begin
        out_zero_d = 1'b1;
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pos_q   <= {LOG2W{1'b0}};
      out_zero_q  <= 1'b0;
      out_frac_q  <= {(WIDTH - 1){1'b0}};
      out_tag_q   <= {TAG_W{1'b0}};
    end else if (en) begin
      out_valid_q <= out_valid_d;
      out_pos_q   <= out_pos_d;
      out_zero_q  <= out_zero_d;
      out_frac_q  <= out_frac_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_pos   = out_pos_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_frac  = out_frac_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_lod_pipe.sv
// Directed bench for lod_pipe at WIDTH 16, 4 and 32: reset, sweeps, mixed
// operands, zero and output backpressure, with hand-computed expectations.
module tb_lod_pipe;

  localparam int LAT16 = 5;
  localparam int LAT4  = 3;
  localparam int LAT32 = 6;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lod_pipe_if #(.WIDTH(16), .TAG_W(4)) bus16 ();
  lod_pipe_if #(.WIDTH(4),  .TAG_W(4)) bus4  ();
  lod_pipe_if #(.WIDTH(32), .TAG_W(4)) bus32 ();

  lod_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  lod_pipe #(.WIDTH(4),  .TAG_W(4)) dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
  lod_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

  // {valid, zero, pos, frac, tag}
  logic [24:0] obs16;
  logic [10:0] obs4;
  logic [41:0] obs32;
  assign obs16 = {bus16.out_valid, bus16.out_zero, bus16.out_pos, bus16.out_frac, bus16.out_tag};
  assign obs4  = {bus4.out_valid,  bus4.out_zero,  bus4.out_pos,  bus4.out_frac,  bus4.out_tag};
  assign obs32 = {bus32.out_valid, bus32.out_zero, bus32.out_pos, bus32.out_frac, bus32.out_tag};

  task automatic idle_all();
    bus16.in_valid = 1'b0; bus16.in_data = 16'h0; bus16.in_tag = 4'h0; bus16.out_ready = 1'b1;
    bus4.in_valid  = 1'b0; bus4.in_data  = 4'h0;  bus4.in_tag  = 4'h0; bus4.out_ready  = 1'b1;
    bus32.in_valid = 1'b0; bus32.in_data = 32'h0; bus32.in_tag = 4'h0; bus32.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [24:0] exp16;
    // Power-on reset, with an operand offered that must not be captured.
    bus16.in_valid = 1'b1; bus16.in_data = 16'hFFFF; bus16.in_tag = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (obs16 !== 25'h0) begin n_fail++; $display("FAIL reset_out16: got %h expected %h", obs16, 25'h0); end
    n_chk++; if (obs4 !== 11'h0) begin n_fail++; $display("FAIL reset_out4: got %h expected %h", obs4, 11'h0); end
    n_chk++; if (obs32 !== 42'h0) begin n_fail++; $display("FAIL reset_out32: got %h expected %h", obs32, 42'h0); end
    n_chk++; if (bus16.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus16.in_ready); end
    rst = 1'b0;
    idle_all();
    for (int c = 0; c < LAT16 + 2; c++) begin
      @(posedge clk); #1;
      n_chk++; if (obs16 !== 25'h0) begin n_fail++; $display("FAIL reset_no_capture[%0d]: got %h expected %h", c, obs16, 25'h0); end
    end
    // Three operands in flight, then reset mid-stream.
    for (int i = 0; i < 3; i++) begin
      bus16.in_valid = 1'b1;
      bus16.in_data  = (i == 0) ? 16'h8000 : (i == 1) ? 16'h00F0 : 16'h0003;
      bus16.in_tag   = 4'(i + 1);
      @(posedge clk); #1;
    end
    idle_all();
    rst = 1'b1;
    #1;
    n_chk++; if (obs16 !== 25'h0) begin n_fail++; $display("FAIL midreset_out: got %h expected %h", obs16, 25'h0); end
    n_chk++; if (bus16.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b expected 1", bus16.in_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < LAT16 + 3; c++) begin
      @(posedge clk); #1;
      n_chk++; if (obs16 !== 25'h0) begin n_fail++; $display("FAIL midreset_flushed[%0d]: got %h expected %h", c, obs16, 25'h0); end
    end
    // First post-reset operand appears LAT edges after its accepting edge.
    bus16.in_valid = 1'b1; bus16.in_data = 16'h0001; bus16.in_tag = 4'h5;
    @(posedge clk); #1;
    idle_all();
    for (int k = 2; k <= LAT16 + 1; k++) begin
      @(posedge clk); #1;
      exp16 = (k == LAT16) ? {1'b1, 1'b0, 4'd0, 15'h0000, 4'h5} : 25'h0;
      n_chk++; if (obs16 !== exp16) begin n_fail++; $display("FAIL postreset_first[edge %0d]: got %h expected %h", k, obs16, exp16); end
    end
  endtask

  task automatic test_sweep16();
    logic [24:0] exp16;
    int k;
    for (int c = 0; c < 16 + LAT16; c++) begin
      if (c < 16) begin
        bus16.in_valid = 1'b1; bus16.in_data = 16'h0001 << c; bus16.in_tag = 4'(c);
      end else begin
        bus16.in_valid = 1'b0; bus16.in_data = 16'h0; bus16.in_tag = 4'h0;
      end
      @(posedge clk); #1;
      k = c - (LAT16 - 1);
      exp16 = (k >= 0 && k < 16) ? {1'b1, 1'b0, 4'(k), 15'h0000, 4'(k)} : 25'h0;
      n_chk++; if (obs16 !== exp16) begin n_fail++; $display("FAIL sweep16[cycle %0d]: got %h expected %h", c, obs16, exp16); end
    end
  endtask

  task automatic test_mixed();
    logic [15:0] d_tab [5];
    logic [24:0] e_tab [5];
    logic [24:0] exp16;
    int k;
    d_tab[0] = 16'h0013; e_tab[0] = {1'b1, 1'b0, 4'd4,  15'h1800, 4'hA};
    d_tab[1] = 16'hFFFF; e_tab[1] = {1'b1, 1'b0, 4'd15, 15'h7FFF, 4'hB};
    d_tab[2] = 16'h0000; e_tab[2] = {1'b1, 1'b1, 4'd0,  15'h0000, 4'hC};
    d_tab[3] = 16'h0100; e_tab[3] = {1'b1, 1'b0, 4'd8,  15'h0000, 4'hD};
    d_tab[4] = 16'h0A50; e_tab[4] = {1'b1, 1'b0, 4'd11, 15'h2500, 4'hE};
    for (int c = 0; c < 5 + LAT16; c++) begin
      if (c < 5) begin
        bus16.in_valid = 1'b1; bus16.in_data = d_tab[c]; bus16.in_tag = 4'(4'hA + c);
      end else begin
        bus16.in_valid = 1'b0; bus16.in_data = 16'h0; bus16.in_tag = 4'h0;
      end
      @(posedge clk); #1;
      k = c - (LAT16 - 1);
      exp16 = (k >= 0 && k < 5) ? e_tab[k] : 25'h0;
      n_chk++; if (obs16 !== exp16) begin n_fail++; $display("FAIL mixed16[cycle %0d]: got %h expected %h", c, obs16, exp16); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d_tab [8];
    logic [24:0] e_tab [8];
    logic [24:0] held;
    int sent, rcv, stalls;
    d_tab[0] = 16'h0001; e_tab[0] = {1'b1, 1'b0, 4'd0,  15'h0000, 4'h0};
    d_tab[1] = 16'h0003; e_tab[1] = {1'b1, 1'b0, 4'd1,  15'h4000, 4'h1};
    d_tab[2] = 16'h00FF; e_tab[2] = {1'b1, 1'b0, 4'd7,  15'h7F00, 4'h2};
    d_tab[3] = 16'h1234; e_tab[3] = {1'b1, 1'b0, 4'd12, 15'h11A0, 4'h3};
    d_tab[4] = 16'h8001; e_tab[4] = {1'b1, 1'b0, 4'd15, 15'h0001, 4'h4};
    d_tab[5] = 16'h0000; e_tab[5] = {1'b1, 1'b1, 4'd0,  15'h0000, 4'h5};
    d_tab[6] = 16'h4000; e_tab[6] = {1'b1, 1'b0, 4'd14, 15'h0000, 4'h6};
    d_tab[7] = 16'h0013; e_tab[7] = {1'b1, 1'b0, 4'd4,  15'h1800, 4'h7};
    sent = 0; rcv = 0; stalls = 0; held = 25'h0;
    for (int c = 0; c < 40; c++) begin
      if (bus16.out_valid && rcv == 2 && stalls < 3) begin
        bus16.out_ready = 1'b0;
        stalls++;
      end else begin
        bus16.out_ready = 1'b1;
      end
      if (sent < 8) begin
        bus16.in_valid = 1'b1; bus16.in_data = d_tab[sent]; bus16.in_tag = 4'(sent);
      end else begin
        bus16.in_valid = 1'b0; bus16.in_data = 16'h0; bus16.in_tag = 4'h0;
      end
      #1;
      if (!bus16.out_ready) begin
        n_chk++; if (bus16.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[cycle %0d]: got %b expected 0", c, bus16.in_ready); end
        if (stalls == 1) begin
          held = obs16;
        end else begin
          n_chk++; if (obs16 !== held) begin n_fail++; $display("FAIL bp_hold[cycle %0d]: got %h expected %h", c, obs16, held); end
        end
      end
      if (bus16.in_valid && bus16.in_ready) sent++;
      if (bus16.out_valid && bus16.out_ready) begin
        n_chk++;
        if (rcv >= 8) begin
          n_fail++; $display("FAIL bp_extra_result[cycle %0d]: got %h expected no result", c, obs16);
        end else if (obs16 !== e_tab[rcv]) begin
          n_fail++; $display("FAIL bp_result[%0d]: got %h expected %h", rcv, obs16, e_tab[rcv]);
        end
        rcv++;
      end
      @(posedge clk); #1;
    end
    n_chk++; if (stalls !== 3) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 3", stalls); end
    n_chk++; if (sent !== 8) begin n_fail++; $display("FAIL bp_sent: got %0d expected 8", sent); end
    n_chk++; if (rcv !== 8) begin n_fail++; $display("FAIL bp_received: got %0d expected 8", rcv); end
    bus16.out_ready = 1'b1;
  endtask

  task automatic test_width4();
    logic [10:0] exp4;
    int k;
    for (int c = 0; c < 5 + LAT4; c++) begin
      if (c < 4) begin
        bus4.in_valid = 1'b1; bus4.in_data = 4'h1 << c; bus4.in_tag = 4'(c);
      end else if (c == 4) begin
        bus4.in_valid = 1'b1; bus4.in_data = 4'h5; bus4.in_tag = 4'h4;
      end else begin
        bus4.in_valid = 1'b0; bus4.in_data = 4'h0; bus4.in_tag = 4'h0;
      end
      @(posedge clk); #1;
      k = c - (LAT4 - 1);
      if (k >= 0 && k < 4)  exp4 = {1'b1, 1'b0, 2'(k), 3'b000, 4'(k)};
      else if (k == 4)      exp4 = {1'b1, 1'b0, 2'd2, 3'b010, 4'h4};
      else                  exp4 = 11'h0;
      n_chk++; if (obs4 !== exp4) begin n_fail++; $display("FAIL sweep4[cycle %0d]: got %h expected %h", c, obs4, exp4); end
    end
  endtask

  task automatic test_width32();
    logic [41:0] exp32;
    int k;
    for (int c = 0; c < 33 + LAT32; c++) begin
      if (c < 32) begin
        bus32.in_valid = 1'b1; bus32.in_data = 32'h1 << c; bus32.in_tag = 4'(c);
      end else if (c == 32) begin
        bus32.in_valid = 1'b1; bus32.in_data = 32'h0001_0003; bus32.in_tag = 4'h9;
      end else begin
        bus32.in_valid = 1'b0; bus32.in_data = 32'h0; bus32.in_tag = 4'h0;
      end
      @(posedge clk); #1;
      k = c - (LAT32 - 1);
      if (k >= 0 && k < 32) exp32 = {1'b1, 1'b0, 5'(k), 31'h0, 4'(k)};
      else if (k == 32)     exp32 = {1'b1, 1'b0, 5'd16, 31'h0001_8000, 4'h9};
      else                  exp32 = 42'h0;
      n_chk++; if (obs32 !== exp32) begin n_fail++; $display("FAIL sweep32[cycle %0d]: got %h expected %h", c, obs32, exp32); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_sweep16();
    test_mixed();
    test_backpressure();
    test_width4();
    test_width32();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
